// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed 7-segment scan driver with shadowed BCD load
// Loads land in a shadow copy and reach the display only at frame start, so a frame never mixes two values.
module seven_seg_scan_driver #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        load_i,
  input  logic [DECIMAL_DIGITS*4-1:0] bcd_i,
  input  logic [DECIMAL_DIGITS-1:0]   dp_i,
  input  logic                        blank_zeros_i,
  output logic [6:0]                  seg_o,
  output logic                        dp_o,
  output logic [DECIMAL_DIGITS-1:0]   an_o,
  output logic                        frame_o
);

  localparam int IW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = DECIMAL_DIGITS * 4;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DECIMAL_DIGITS - 1);

  // XOR masks that turn the active-high internal form into pin polarity
  localparam logic [6:0]                SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                      DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DECIMAL_DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_idx;
  logic [BW-1:0]             r_shadow_bcd;
  logic [DECIMAL_DIGITS-1:0] r_shadow_dp;
  logic                      r_pending;
  logic [BW-1:0]             r_disp_bcd;
  logic [DECIMAL_DIGITS-1:0] r_disp_dp;
  logic [6:0]                r_seg;
  logic                      r_dp;
  logic [DECIMAL_DIGITS-1:0] r_an;
  logic                      r_frame;

  state_t                    w_state_next;
  logic [CW-1:0]             w_cnt_next;
  logic [IW-1:0]             w_idx_next;
  logic                      w_frame_start;
  logic                      w_pending_next;
  logic [BW-1:0]             w_disp_bcd_next;
  logic [DECIMAL_DIGITS-1:0] w_disp_dp_next;
  logic [DECIMAL_DIGITS-1:0] w_lz;
  logic                      w_zero_run;
  logic [3:0]                w_digit;
  logic                      w_dp_sel;
  logic                      w_lz_sel;
  logic                      w_drive;
  logic [6:0]                w_seg_next;
  logic                      w_dp_next;
  logic [DECIMAL_DIGITS-1:0] w_an_next;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_frame_start = 1'b0;
    if (!enable_i) begin
      w_state_next = ST_OFF;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        ST_BLANK, ST_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_next    = '0;
              w_frame_start = 1'b1;
            end else begin
              w_idx_next = r_idx + IW'(1);
            end
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: begin
          w_cnt_next    = '0;
          w_idx_next    = '0;
          w_frame_start = 1'b1;
        end
      endcase
      // Slot phase is a pure function of the counter; BLANK_CYCLES=0 skips BLANK.
      w_state_next = (w_cnt_next < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
    end
  end

  always_comb begin
    w_pending_next  = load_i | (r_pending & ~w_frame_start);
    w_disp_bcd_next = r_disp_bcd;
    w_disp_dp_next  = r_disp_dp;
    if (w_frame_start && r_pending) begin
      w_disp_bcd_next = r_shadow_bcd;
      w_disp_dp_next  = r_shadow_dp;
    end
  end

  // Outputs are decoded from next-state values so they register on the same edge as idx/cnt.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (w_disp_bcd_next[k*4 +: 4] == 4'd0);
      w_lz[k]    = w_zero_run & (k != 0);
    end
    w_drive  = (w_state_next == ST_DRIVE);
    w_digit  = '0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    w_an_next = '0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      if (w_idx_next == IW'(k)) begin
        w_digit      = w_disp_bcd_next[k*4 +: 4];
        w_dp_sel     = w_disp_dp_next[k];
        w_lz_sel     = w_lz[k];
        w_an_next[k] = w_drive;
      end
    end
    w_seg_next = (w_drive && !(blank_zeros_i && w_lz_sel)) ? f_decode(w_digit) : 7'h00;
    w_dp_next  = w_drive & w_dp_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_bcd <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_disp_bcd   <= '0;
      r_disp_dp    <= '0;
      r_seg        <= SEG_POL;
      r_dp         <= DP_POL;
      r_an         <= AN_POL;
      r_frame      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_pending  <= w_pending_next;
      r_disp_bcd <= w_disp_bcd_next;
      r_disp_dp  <= w_disp_dp_next;
      if (load_i) begin
        r_shadow_bcd <= bcd_i;
        r_shadow_dp  <= dp_i;
      end
      r_seg   <= w_seg_next ^ SEG_POL;
      r_dp    <= w_dp_next ^ DP_POL;
      r_an    <= w_an_next ^ AN_POL;
      r_frame <= w_frame_start;
    end
  end

  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for seven_seg_scan_driver
// Expected outputs come from a slot-position model: position since enable gives digit and phase.
module tb_seven_seg_scan_driver;

  localparam int N     = 3;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        enable_i = 1'b0;
  logic        load_i = 1'b0;
  logic [11:0] bcd_i = '0;
  logic [2:0]  dp_i = '0;
  logic        blank_zeros_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [2:0]  an_o;
  logic        frame_o;

  seven_seg_scan_driver #(
    .DECIMAL_DIGITS(N),
    .REFRESH_DIV(RD),
    .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .load_i(load_i),
    .bcd_i(bcd_i),
    .dp_i(dp_i),
    .blank_zeros_i(blank_zeros_i),
    .seg_o(seg_o),
    .dp_o(dp_o),
    .an_o(an_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;
    logic       frame;
    int         s;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model: s = position within the frame (-1 when dark); last_* = most recent load.
  int          s = -1;
  logic [11:0] last_bcd = '0;
  logic [2:0]  last_dp = '0;
  logic [11:0] disp_bcd = '0;
  logic [2:0]  disp_dp = '0;
  logic        cur_bz = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("seg(s=%0d)", e.s), {1'b0, seg_o}, {1'b0, e.seg});
      chk($sformatf("dp(s=%0d)", e.s), {7'b0, dp_o}, {7'b0, e.dp});
      chk($sformatf("an(s=%0d)", e.s), {5'b0, an_o}, {5'b0, e.an});
      chk($sformatf("frame(s=%0d)", e.s), {7'b0, frame_o}, {7'b0, e.frame});
    end
  end

  task automatic step(input logic en, input logic ld, input logic [11:0] bcd,
                      input logic [2:0] dp, input logic bz);
    exp_t       e;
    int         digit, sub;
    logic       frame, drive, sup;
    logic [3:0] d;
    logic [6:0] seg;
    @(negedge clk);
    enable_i = en; load_i = ld; bcd_i = bcd; dp_i = dp; blank_zeros_i = bz;
    frame = 1'b0;
    if (!en) s = -1;
    else begin
      s = (s < 0) ? 0 : (s + 1) % FRAME;
      frame = (s == 0);
    end
    if (frame) begin
      disp_bcd = last_bcd;
      disp_dp  = last_dp;
    end
    if (ld) begin
      last_bcd = bcd;
      last_dp  = dp;
    end
    digit = (s < 0) ? 0 : s / RD;
    sub   = (s < 0) ? 0 : s % RD;
    drive = en && (sub >= BC);
    d     = disp_bcd[digit*4 +: 4];
    sup   = 1'b0;
    if (bz && digit >= 1) begin
      sup = 1'b1;
      for (int j = digit; j < N; j++) if (disp_bcd[j*4 +: 4] != 4'd0) sup = 1'b0;
    end
    seg     = (drive && !sup) ? seg_tab[d] : 7'h00;
    e.seg   = ~seg;
    e.dp    = ~(drive & disp_dp[digit]);
    e.an    = drive ? ~(3'b001 << digit) : 3'b111;
    e.frame = frame;
    e.s     = s;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0, 12'($urandom), 3'($urandom), cur_bz);
  endtask

  task automatic load(input logic [11:0] bcd, input logic [2:0] dp);
    step(1'b1, 1'b1, bcd, dp, cur_bz);
  endtask

  task automatic run_until(input int tgt);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 12'($urandom), 3'($urandom), cur_bz);
      n++;
    end while (s != tgt && n < 100);
    tests++;
    if (s != tgt) begin
      fails++;
      $display("FAIL run_until: position %0d expected %0d", s, tgt);
    end
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int k = 0; k < N; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 3) v[k*4 +: 4] = 4'd0;
      else if (r < 8) v[k*4 +: 4] = 4'($urandom_range(0, 9));
      else v[k*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, {5'b0, an_o}, 8'h07);
    chk({tag, "_seg"}, {1'b0, seg_o}, 8'h7F);
    chk({tag, "_dp"}, {7'b0, dp_o}, 8'h01);
    chk({tag, "_frame"}, {7'b0, frame_o}, 8'h00);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    load(12'h255, 3'b010);
    idle(60, 1'b1);

    cur_bz = 1'b1;
    load(12'h007, 3'b000);
    idle(50, 1'b1);
    load(12'h000, 3'b000);
    idle(50, 1'b1);
    cur_bz = 1'b0;

    run_until(RD + 3);
    load(12'h123, 3'b100);
    run_until(FRAME - 1);
    load(12'h456, 3'b001);
    idle(55, 1'b1);

    load(12'hA0F, 3'b101);
    idle(50, 1'b1);

    run_until(RD + 4);
    idle(3, 1'b0);
    idle(30, 1'b1);

    run_until(RD + 5);
    @(posedge clk);
    #3;
    enable_i = 1'b0;
    load_i   = 1'b0;
    rst_ni   = 1'b0;
    #1 check_reset_outputs("rst_mid");
    s = -1; last_bcd = '0; last_dp = '0; disp_bcd = '0; disp_dp = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    idle(30, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic en, ld;
      en = ($urandom_range(0, 99) >= 2);
      ld = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 2) cur_bz = ~cur_bz;
      step(en, ld, rand_bcd(), 3'($urandom), cur_bz);
    end

    idle(4, 1'b1);
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures a packed BCD word on a load strobe, which is normally wired to the converter's `done_o`. It then time-multiplexes the digits onto a shared segment bus with per-digit anode enables. Each digit slot includes an anti-ghosting blank interval, optional leading-zero suppression, and tear-free updates applied only at frame boundaries.

## Interface
- `DECIMAL_DIGITS`, 3: number of digits and anodes, ≥1.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, ≥2.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all anodes off, 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg_o` and `dp_o`.
- `AN_ACTIVE_LOW`, 1: 1 inverts `an_o`.
- `clk_i`  in  1  sole clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  scanning enable; low forces display dark.
- `load_i`  in  1  single-cycle strobe; capture `bcd_i`/`dp_i`.
- `bcd_i`  in  DECIMAL_DIGITS*4  packed BCD, digit 0 (least significant) in bits [3:0].
- `dp_i`  in  DECIMAL_DIGITS  decimal point per digit, bit k = digit k.
- `blank_zeros_i`  in  1  enable leading-zero suppression.
- `seg_o`  out  7  segments, bit0=a … bit6=g.
- `dp_o`  out  1  decimal-point segment.
- `an_o`  out  DECIMAL_DIGITS  anode enables, bit k = digit k.
- `frame_o`  out  1  one-cycle pulse at each frame start.

## Operation
- Registers:
  - Shadow (`shadow_bcd`, `shadow_dp`, `pending`).
  - Display (`disp_bcd`, `disp_dp`).
  - Slot counter `cnt` (0..REFRESH_DIV-1).
  - Digit index `idx` (0..DECIMAL_DIGITS-1).
  - State.
- States:
  - **OFF**: scanning stopped.
  - **BLANK**: `cnt` < BLANK_CYCLES; all anodes off.
  - **DRIVE**: `cnt` ≥ BLANK_CYCLES; `an_o` bit `idx` active.
- Transitions:
  - OFF → BLANK when `enable_i`=1. This transition starts a frame: `idx`=0, `cnt`=0.
  - BLANK → DRIVE when `cnt` reaches BLANK_CYCLES. With BLANK_CYCLES=0, BLANK is never entered and a slot starts directly in DRIVE.
  - DRIVE at `cnt`=REFRESH_DIV-1 → `cnt`←0, next slot begins. `idx` increments, and wraps DECIMAL_DIGITS-1 → 0.
  - A wrap to 0 is a frame start.
  - Any state → OFF on the next edge when `enable_i`=0. `cnt` and `idx` clear.
- Load:
  - `load_i`=1 writes `bcd_i`/`dp_i` into the shadow registers and sets `pending`.
  - Repeated loads overwrite the shadow; the last one wins.
- Frame start:
  - If `pending`, copy shadow → display and clear `pending`.
  - Pulse `frame_o` whether or not a copy occurs.
  - If `load_i` is high in the same cycle as a frame start, the copy uses the old shadow. The new value is captured, `pending` stays set, and the new value is applied at the following frame start.
- Decode, active-high form before polarity inversion:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10–15 display as dash 0x40.
- Leading-zero blank: digit k ≥ 1 shows segments 0x00 when `blank_zeros_i`=1 and every display digit from DECIMAL_DIGITS-1 down to k equals 0.
  - Digit 0 is never suppressed.
  - `dp_o` follows `disp_dp[idx]` regardless of suppression.
- In BLANK and OFF: `an_o` all inactive, segments 0x00, `dp_o` off, each after polarity applied.

## Timing
- Reset (`rst_ni`=0, immediate):
  - State OFF, `cnt`=0, `idx`=0.
  - Shadow, display and `pending` cleared.
  - `an_o` all inactive, `seg_o`/`dp_o` off (all-ones when active-low), `frame_o`=0.
- Reset mid-scan discards any pending load.
- All outputs are registered. There is no combinational path from any input to any output.
- Output latency:
  - `an_o`/`seg_o` change on the same edge that updates state, `cnt` and `idx`.
  - A new load becomes visible at the next frame start, at most DECIMAL_DIGITS*REFRESH_DIV + 1 cycles after `load_i`.
- Frame period is DECIMAL_DIGITS*REFRESH_DIV cycles. Each digit is driven for REFRESH_DIV − BLANK_CYCLES cycles.
- `frame_o` is high for exactly one cycle, coincident with the first BLANK (or DRIVE) cycle of digit 0.
- Changes on `blank_zeros_i` take effect on the next output update; this input is not shadowed.

## Test plan
All scenarios use parameters DECIMAL_DIGITS=3, REFRESH_DIV=8, BLANK_CYCLES=2, both polarities active-low.

- **Reset:** assert `rst_ni`=0 mid-DRIVE → `an_o`=3'b111, `seg_o`=7'h7F, `dp_o`=1, `frame_o`=0 immediately, without waiting for a clock edge.
- **Basic scan:** enable, load `bcd_i`=12'h255, `dp_i`=3'b010 →
  - After the next `frame_o`, the slot sequence is 2 blank cycles then 6 drive cycles per digit.
  - Per digit: `an_o`=110 with `seg_o`=~0x6D; 101 with ~0x6D and `dp_o`=0; 011 with ~0x5B.
  - Frame period is 24 cycles.
- **Leading zeros:** load 12'h007 with `blank_zeros_i`=1 → digits 2 and 1 show `seg_o`=7'h7F, digit 0 shows ~0x07. Load 12'h000 → digit 0 shows ~0x3F.
- **Tear-free update:** load 12'h123 at the middle of digit 1 → digits 1 and 2 keep the old value until the next `frame_o`. Load 12'h456 on the exact `frame_o` cycle → 12'h123 is displayed for that frame and 12'h456 from the next frame.
- **Invalid code:** load 12'hA0F → digits 2 and 0 show dash ~0x40, digit 1 shows ~0x3F.
- **Enable drop:** `enable_i`=0 mid-DRIVE → next edge `an_o`=111. Re-enable → `frame_o` fires one cycle later with `idx`=0 and `cnt`=0.
